// File: rtl/sync_pkg.sv
// Shared constants and the filter-threshold helper for the sync_filter block.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int FILT_CYC_DEF    = 4;
  localparam int FILT_W_DEF      = 4;

  // True when the pending change has been seen for the full threshold,
  // counting the current edge. Uses >= so that lowering the threshold
  // mid-count accepts the change on the very next edge.
  function automatic logic filt_done(input int unsigned cnt,
                                     input logic        filt_en,
                                     input int unsigned filt_cyc);
    int unsigned thr;
    thr = filt_en ? filt_cyc : 32'd1;
    return (cnt + 32'd1) >= thr;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel of sync_filter: synchroniser chain, stability counter,
// registered level and optional rise/fall pulse registers.
// Optional feature macro: SYNC_FILTER_EDGE_EN (edge pulse registers).
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES   = SYNC_MIN_STAGES,
  parameter int   FILT_W   = FILT_W_DEF,
  parameter int   FILT_CYC = FILT_CYC_DEF,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_filt_en,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  logic [STAGES-1:0] r_sync;
  logic [FILT_W-1:0] r_cnt;
  logic              r_q;
  logic              r_busy;
  logic              w_sync;
  logic              w_diff;
  logic              w_take;
  logic [FILT_W-1:0] w_cnt_nxt;

  assign w_sync = r_sync[STAGES-1];
  assign w_diff = w_sync ^ r_q;
  assign w_take = w_diff && filt_done(32'(r_cnt), i_filt_en, FILT_CYC);

  // Next counter value: count while a difference persists, clear otherwise.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_diff && !w_take) begin
      w_cnt_nxt = r_cnt + FILT_W'(1);
    end
  end

  // Plain flop chain, no logic between stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_BIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  // Stability counter, accepted level and busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_q    <= RST_BIT;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= |w_cnt_nxt;
      if (w_take) begin
        r_q <= w_sync;
      end
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;

`ifdef SYNC_FILTER_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses line up with the cycle in which o_q first shows its new value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_take &  w_sync;
      r_fall <= w_take & ~w_sync;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter.sv
// sync_filter: CH independent single-bit input conditioners.
// Each bit is synchronised and debounced on its own; do not use for buses
// that need coherent multi-bit capture.
// Optional feature macro: SYNC_FILTER_EDGE_EN (O_RISE/O_FALL pulses;
// tied to 0 when undefined, ports kept).
module sync_filter
  import sync_pkg::*;
#(
  parameter int            CH       = 4,
  parameter int            STAGES   = SYNC_MIN_STAGES,
  parameter int            FILT_W   = FILT_W_DEF,
  parameter int            FILT_CYC = FILT_CYC_DEF,
  parameter logic [CH-1:0] RST_VAL  = '0
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic [CH-1:0] I_D,
  input  logic          I_FILT_EN,
  output logic [CH-1:0] O_Q,
  output logic [CH-1:0] O_RISE,
  output logic [CH-1:0] O_FALL,
  output logic [CH-1:0] O_BUSY
);

  // Reject configurations the counter or chain cannot support.
  if (CH < 1) begin : g_bad_ch
    $error("sync_filter: CH must be >= 1");
  end
  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filter: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILT_CYC < 1 || FILT_CYC > (2 ** FILT_W) - 1) begin : g_bad_filt
    $error("sync_filter: FILT_CYC must be in 1..2^FILT_W-1");
  end

  // One independent conditioner per channel, sharing the filter enable.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES   (STAGES),
      .FILT_W   (FILT_W),
      .FILT_CYC (FILT_CYC),
      .RST_BIT  (RST_VAL[i])
    ) u_ch (
      .i_clk     (I_CLK),
      .i_rst_n   (I_RST_N),
      .i_d       (I_D[i]),
      .i_filt_en (I_FILT_EN),
      .o_q       (O_Q[i]),
      .o_rise    (O_RISE[i]),
      .o_fall    (O_FALL[i]),
      .o_busy    (O_BUSY[i])
    );
  end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised multi-channel input conditioner for asynchronous single-bit signals entering the I_CLK domain.
- Per-channel datapath: STAGES-deep synchroniser chain, then a stability filter (glitch/debounce counter), then registered level output with rise/fall pulses.
- Sits at chip-level inputs (buttons, external status lines, slow cross-domain flags).
- Channels are independent single bits. Multi-bit buses needing coherence must not use this block.

Parameters:
- CH, 4, number of independent 1-bit channels (>=1).
- STAGES, 2, synchroniser flops per channel (>=2; elaboration error otherwise).
- FILT_W, 4, filter counter width in bits.
- FILT_CYC, 4, consecutive stable cycles needed to accept a change (1..2^FILT_W-1; elaboration error otherwise).
- RST_VAL, {CH{1'b0}}, per-channel reset value of sync chain and O_Q.

Ports:
- I_CLK  in  1  sole clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_D  in  CH  asynchronous raw inputs.
- I_FILT_EN  in  1  synchronous: 1 = filter active; 0 = bypass (FILT_CYC treated as 1).
- O_Q  out  CH  filtered, synchronised level.
- O_RISE  out  CH  1-cycle pulse on O_Q 0->1.
- O_FALL  out  CH  1-cycle pulse on O_Q 1->0.
- O_BUSY  out  CH  filter counter nonzero (change pending).

Behaviour:
- Clock/reset: one clock, I_CLK. I_RST_N is asynchronous active-low, all flops reset on its falling edge, release synchronous to I_CLK (release synchronised upstream).
- Reset values: every sync flop and O_Q[i] = RST_VAL[i]; counters = 0; O_RISE = O_FALL = O_BUSY = 0.
- Sync chain: s[0] <= I_D; s[k] <= s[k-1]; sync output = s[STAGES-1]. No logic between chain flops.
- Filter, per channel, evaluated each edge:
  - sync == O_Q: cnt <= 0.
  - sync != O_Q and cnt < thr-1: cnt <= cnt+1.
  - sync != O_Q and cnt == thr-1: O_Q <= sync; cnt <= 0.
  - thr = FILT_CYC when I_FILT_EN=1, else 1.
- Latency: I_D stable from before edge 1 → O_Q updates at edge STAGES+thr. Default STAGES=2, FILT_CYC=4 → 6 cycles.
- Glitch rejection: a sync-output pulse shorter than thr cycles resets the counter and never reaches O_Q. No partial credit carries over.
- Toggle I_FILT_EN mid-count: new thr applies next edge. If cnt >= new thr-1 and sync still differs, O_Q updates on that edge.
- Edge pulses: O_RISE/O_FALL registered, high exactly the cycle O_Q holds its new value; never both high; never high in or immediately after reset.
- O_BUSY[i] = (cnt[i] != 0), registered.
- Counter arithmetic never exceeds thr-1; no wrap. FILT_W is only sized to hold FILT_CYC.
- Reset mid-count: counters cleared, O_Q returns to RST_VAL immediately. No pulses generated by reset.

Optional Feature:
- Macro SYNC_FILTER_EDGE_EN.
- Defined: O_RISE/O_FALL behave as above.
- Undefined: edge registers are not built. O_RISE/O_FALL are tied to 0 and ports remain, so the interface is unchanged.

Decomposition:
- Shared package sync_pkg:
  - SYNC_MIN_STAGES = 2
  - default FILT_CYC / FILT_W constants
  - filter-threshold compare helper function
- Sub-module sync_filter_ch: one channel (chain + counter + edge regs). The top generates CH instances and wires I_FILT_EN to all of them.

Test Plan:
- Reset with RST_VAL=4'b0101, I_D=4'b1010 held → O_Q=4'b0101 during reset; O_Q=4'b1010 at edge 6 after release; O_RISE[1]/O_RISE[3] and O_FALL[0]/O_FALL[2] pulse once.
- I_D[0] 0->1 held, defaults → O_Q[0] rises at edge 6; O_BUSY[0] high edges 3-5; O_RISE[0] high one cycle.
- 3-cycle glitch on I_D[2] with FILT_CYC=4 → O_Q[2] unchanged, no pulses; O_BUSY[2] high then cleared.
- I_FILT_EN=0, I_D[1] toggles → O_Q[1] follows at STAGES+1 = 3 cycles.
- I_RST_N asserted with cnt=2 on channel 3 → cnt=0, O_Q[3]=RST_VAL[3], no O_FALL/O_RISE.
- Build without SYNC_FILTER_EDGE_EN → O_RISE/O_FALL constant 0 across the previous scenarios, O_Q timing identical.
